// File: rtl/rgu_ray_packer_pkg.sv
// -----------------------------------------------------------------------------
// rgu_ray_packer_pkg
// Shared definitions for the RGU ray packer: ray-record geometry and the
// word-slot encoding used by the packer's word counter.
//   RGU_RAY_WORDS      : words per ray record (x, y, z)
//   RGU_RAY_SZ         : record width for the default 32-bit word
//   RGU_RAY_*_LSB/MSB  : field ranges of x, y, z inside a default record
// -----------------------------------------------------------------------------
package rgu_ray_packer_pkg;

    localparam int RGU_RAY_WORDS = 3;
    localparam int RGU_WORD_SZ   = 32;
    localparam int RGU_RAY_SZ    = RGU_RAY_WORDS * RGU_WORD_SZ;

    localparam int RGU_RAY_X_LSB = 0;
    localparam int RGU_RAY_X_MSB = RGU_WORD_SZ - 1;
    localparam int RGU_RAY_Y_LSB = RGU_WORD_SZ;
    localparam int RGU_RAY_Y_MSB = 2 * RGU_WORD_SZ - 1;
    localparam int RGU_RAY_Z_LSB = 2 * RGU_WORD_SZ;
    localparam int RGU_RAY_Z_MSB = 3 * RGU_WORD_SZ - 1;

    // Which word of the current ray the next push delivers.
    typedef enum logic [1:0] {
        WC_X = 2'd0,
        WC_Y = 2'd1,
        WC_Z = 2'd2
    } wc_e;

endpackage

// File: rtl/rgu_ray_packer_mem.sv
// -----------------------------------------------------------------------------
// rgu_ray_packer_mem
// DEPTH x REC_W register array for buffered ray records. One synchronous
// write port, one combinational (show-ahead) read port. Storage is not reset.
// Ports:
//   iClock   : clock
//   iWrEn    : write strobe
//   iWrAddr  : write address
//   iWrData  : write record
//   iRdAddr  : read address
//   oRdData  : record at iRdAddr (combinational)
// -----------------------------------------------------------------------------
module rgu_ray_packer_mem #(
    parameter int DEPTH = 8,
    parameter int REC_W = 96
) (
    input  logic                     iClock,
    input  logic                     iWrEn,
    input  logic [$clog2(DEPTH)-1:0] iWrAddr,
    input  logic [REC_W-1:0]         iWrData,
    input  logic [$clog2(DEPTH)-1:0] iRdAddr,
    output logic [REC_W-1:0]         oRdData
);

    logic [REC_W-1:0] mem_q [DEPTH];

    always_ff @(posedge iClock) begin
        if (iWrEn) begin
            mem_q[iWrAddr] <= iWrData;
        end
    end

    assign oRdData = mem_q[iRdAddr];

endmodule

// File: rtl/rgu_ray_packer.sv
// -----------------------------------------------------------------------------
// rgu_ray_packer
// Collects 32-bit words pushed by the ray generation unit and packs every
// three consecutive words (x, y, z) into one record {z, y, x}. Records are
// buffered in a DEPTH-entry FIFO and offered over a valid/ready handshake.
// The RGU cannot be stalled, so a full FIFO drops whole rays and sets a
// sticky overflow flag; oAlmostFull leaves one spare slot for RGU latency.
//
// Optional feature macro: RGU_RAY_PACKER_DROP_CNT_EN adds oDropCount, a
// saturating 16-bit count of dropped rays.
//
// Ports:
//   iClock, iReset_n  : clock, asynchronous active-low reset
//   iPush, iData      : word strobe and word from the RGU
//   iFlush            : synchronous clear of all buffered and partial data
//   oRayValid         : head record available
//   iRayReady         : consumer accepts head record
//   oRayData          : head record {z, y, x}
//   oCount            : complete records stored
//   oFull             : oCount == DEPTH
//   oAlmostFull       : oCount >= DEPTH-1
//   oOverflow         : sticky ray-dropped flag
//   oDropCount        : dropped-ray counter (macro enabled only)
// -----------------------------------------------------------------------------
module rgu_ray_packer
    import rgu_ray_packer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int WORD_W = 32
) (
    input  logic                             iClock,
    input  logic                             iReset_n,
    input  logic                             iPush,
    input  logic [WORD_W-1:0]                iData,
    input  logic                             iFlush,
    output logic                             oRayValid,
    input  logic                             iRayReady,
    output logic [RGU_RAY_WORDS*WORD_W-1:0]  oRayData,
    output logic [$clog2(DEPTH):0]           oCount,
    output logic                             oFull,
    output logic                             oAlmostFull,
    output logic                             oOverflow
`ifdef RGU_RAY_PACKER_DROP_CNT_EN
    ,
    output logic [15:0]                      oDropCount
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = RGU_RAY_WORDS * WORD_W;

    wc_e               wc_q, wc_d;
    logic [2*WORD_W-1:0] asm_q, asm_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;

    logic              pop;
    logic              ray_done;
    logic              wr_en;
    logic              drop;
    logic              mem_we;
    logic [REC_W-1:0]  wr_rec;

`ifdef RGU_RAY_PACKER_DROP_CNT_EN
    logic [15:0]       drop_cnt_q, drop_cnt_d;
`endif

    // Flags decode the registered count only, so nothing here depends
    // combinationally on iPush.
    assign oCount      = count_q;
    assign oRayValid   = (count_q != '0);
    assign oFull       = (count_q == CW'(DEPTH));
    assign oAlmostFull = (count_q >= CW'(DEPTH - 1));
    assign oOverflow   = ovf_q;

    assign pop      = oRayValid && iRayReady;
    assign ray_done = iPush && (wc_q == WC_Z);
    // A full FIFO still accepts the ray if the head leaves this same cycle.
    assign wr_en    = ray_done && (!oFull || pop);
    assign drop     = ray_done && !wr_en;
    assign mem_we   = wr_en && !iFlush;
    assign wr_rec   = {iData, asm_q};

    always_comb begin
        wc_d     = wc_q;
        asm_d    = asm_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (iFlush) begin
            wc_d     = WC_X;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (iPush) begin
                case (wc_q)
                    WC_X:    begin asm_d[WORD_W-1:0]        = iData; wc_d = WC_Y; end
                    WC_Y:    begin asm_d[2*WORD_W-1:WORD_W] = iData; wc_d = WC_Z; end
                    default: wc_d = WC_X;
                endcase
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            wc_q     <= WC_X;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wc_q     <= wc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // x/y holding register is pure data; wc alone says whether it is valid.
    always_ff @(posedge iClock) begin
        asm_q <= asm_d;
    end

`ifdef RGU_RAY_PACKER_DROP_CNT_EN
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (iFlush) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign oDropCount = drop_cnt_q;
`endif

    rgu_ray_packer_mem #(
        .DEPTH (DEPTH),
        .REC_W (REC_W)
    ) u_mem (
        .iClock  (iClock),
        .iWrEn   (mem_we),
        .iWrAddr (wr_ptr_q),
        .iWrData (wr_rec),
        .iRdAddr (rd_ptr_q),
        .oRdData (oRayData)
    );

endmodule

// File: tb/tb_rgu_ray_packer.sv
module tb_rgu_ray_packer;

    logic        iClock;
    logic        iReset_n;
    logic        iPush;
    logic [31:0] iData;
    logic        iFlush;
    logic        oRayValid;
    logic        iRayReady;
    logic [95:0] oRayData;
    logic [3:0]  oCount;
    logic        oFull;
    logic        oAlmostFull;
    logic        oOverflow;
`ifdef RGU_RAY_PACKER_DROP_CNT_EN
    logic [15:0] oDropCount;
`endif

    int checks   = 0;
    int failures = 0;

    rgu_ray_packer #(.DEPTH(8), .WORD_W(32)) dut (
        .iClock      (iClock),
        .iReset_n    (iReset_n),
        .iPush       (iPush),
        .iData       (iData),
        .iFlush      (iFlush),
        .oRayValid   (oRayValid),
        .iRayReady   (iRayReady),
        .oRayData    (oRayData),
        .oCount      (oCount),
        .oFull       (oFull),
        .oAlmostFull (oAlmostFull),
        .oOverflow   (oOverflow)
`ifdef RGU_RAY_PACKER_DROP_CNT_EN
        ,
        .oDropCount  (oDropCount)
`endif
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge.
    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        iPush = 1'b1;
        iData = w;
        tick();
        iPush = 1'b0;
        iData = '0;
    endtask

    task automatic push_ray(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        push(x);
        push(y);
        push(z);
    endtask

    function automatic logic [95:0] rec(input int k);
        logic [31:0] x, y, z;
        x = 32'h100 + 32'(k);
        y = 32'h200 + 32'(k);
        z = 32'h300 + 32'(k);
        return {z, y, x};
    endfunction

    task automatic flush();
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
    endtask

    initial begin
        iReset_n  = 1'b0;
        iPush     = 1'b0;
        iData     = '0;
        iFlush    = 1'b0;
        iRayReady = 1'b0;
        #23;
        chk("rst_valid", 96'(oRayValid), 96'd0);
        chk("rst_count", 96'(oCount), 96'd0);
        chk("rst_full", 96'(oFull), 96'd0);
        chk("rst_afull", 96'(oAlmostFull), 96'd0);
        chk("rst_ovf", 96'(oOverflow), 96'd0);
        @(negedge iClock);
        iReset_n = 1'b1;
        tick();

        // Single ray
        push(32'h0001_0000);
        push(32'hFFFF_0000);
        push(32'h0000_8000);
        chk("single_valid", 96'(oRayValid), 96'd1);
        chk("single_data", oRayData, 96'h0000_8000_FFFF_0000_0001_0000);
        chk("single_count", 96'(oCount), 96'd1);
        iRayReady = 1'b1;
        tick();
        iRayReady = 1'b0;
        chk("single_pop_valid", 96'(oRayValid), 96'd0);

        // Fill and overflow
        for (int k = 1; k <= 9; k++) begin
            push_ray(32'h100 + 32'(k), 32'h200 + 32'(k), 32'h300 + 32'(k));
            if (k == 6) begin
                chk("fill6_afull", 96'(oAlmostFull), 96'd0);
            end else if (k == 7) begin
                chk("fill7_afull", 96'(oAlmostFull), 96'd1);
                chk("fill7_full", 96'(oFull), 96'd0);
            end else if (k == 8) begin
                chk("fill8_full", 96'(oFull), 96'd1);
                chk("fill8_ovf", 96'(oOverflow), 96'd0);
            end
        end
        chk("fill9_count", 96'(oCount), 96'd8);
        chk("fill9_ovf", 96'(oOverflow), 96'd1);
`ifdef RGU_RAY_PACKER_DROP_CNT_EN
        chk("fill9_dropcnt", 96'(oDropCount), 96'd1);
`endif
        iRayReady = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain_%0d", k), oRayData, rec(k));
            tick();
        end
        iRayReady = 1'b0;
        chk("drain_empty", 96'(oRayValid), 96'd0);
        chk("drain_ovf_sticky", 96'(oOverflow), 96'd1);
        flush();
        chk("flush_ovf", 96'(oOverflow), 96'd0);

        // Write and pop while full
        for (int k = 1; k <= 8; k++) begin
            push_ray(32'h100 + 32'(k), 32'h200 + 32'(k), 32'h300 + 32'(k));
        end
        push(32'h109);
        push(32'h209);
        iRayReady = 1'b1;
        push(32'h309);
        iRayReady = 1'b0;
        chk("wfull_count", 96'(oCount), 96'd8);
        chk("wfull_ovf", 96'(oOverflow), 96'd0);
        iRayReady = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            chk($sformatf("wfull_drain_%0d", k), oRayData, rec(k));
            tick();
        end
        iRayReady = 1'b0;
        chk("wfull_empty", 96'(oCount), 96'd0);

        // Pointer wrap: 20 rays streamed with continuous ready
        iRayReady = 1'b1;
        for (int k = 0; k < 20; k++) begin
            push_ray(32'(k), 32'h5000 + 32'(k), 32'h6000 + 32'(k));
            chk($sformatf("wrap_count_%0d", k), 96'(oCount), 96'd1);
            chk($sformatf("wrap_data_%0d", k), oRayData,
                {32'h6000 + 32'(k), 32'h5000 + 32'(k), 32'(k)});
        end
        tick();
        iRayReady = 1'b0;
        chk("wrap_empty", 96'(oCount), 96'd0);

        // Gapped words then flush
        push(32'hDEAD_BEEF);
        repeat (5) tick();
        push(32'hCAFE_F00D);
        flush();
        chk("gap_flush_count", 96'(oCount), 96'd0);
        push_ray(32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003);
        chk("gap_count", 96'(oCount), 96'd1);
        chk("gap_data", oRayData, 96'hC0C0_0003_B0B0_0002_A0A0_0001);
        flush();

        // Mid-operation asynchronous reset
        for (int k = 1; k <= 3; k++) begin
            push_ray(32'h100 + 32'(k), 32'h200 + 32'(k), 32'h300 + 32'(k));
        end
        push(32'h7777_7777);
        chk("pre_rst_count", 96'(oCount), 96'd3);
        #2;
        iReset_n = 1'b0;
        #1;
        chk("arst_valid", 96'(oRayValid), 96'd0);
        chk("arst_count", 96'(oCount), 96'd0);
        chk("arst_full", 96'(oFull), 96'd0);
        chk("arst_afull", 96'(oAlmostFull), 96'd0);
        chk("arst_ovf", 96'(oOverflow), 96'd0);
        @(negedge iClock);
        iReset_n = 1'b1;
        tick();
        push_ray(32'h1111_0001, 32'h2222_0002, 32'h3333_0003);
        chk("post_rst_count", 96'(oCount), 96'd1);
        chk("post_rst_data", oRayData, 96'h3333_0003_2222_0002_1111_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
